// File: rtl/alu_defs_pkg.sv
// Shared ALU definitions.
//   ALU_WIDTH          data width of the single-cycle ALU
//   ALU_FWD..ALU_OR    ALU SELECT opcodes
//   seq_state_t        state encoding of the multiply sequencer
package alu_defs_pkg;

  localparam int ALU_WIDTH = 8;

  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// Bus between the CPU/ALU environment and the multiply sequencer.
//   start, opa, opb            multiply request and operands
//   cpu_data1/2, cpu_select    CPU's intended ALU inputs
//   alu_result                 combinational result of the shared ALU
//   alu_data1/2, alu_select    what actually reaches the ALU
//   product, busy, done, stall sequencer status back to the CPU
// master: CPU/ALU side. slave: the sequencer.
interface alu_mul_sequencer_if import alu_defs_pkg::*; #(
  parameter int WIDTH = ALU_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] cpu_data1;
  logic [WIDTH-1:0] cpu_data2;
  logic [2:0]       cpu_select;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] alu_data1;
  logic [WIDTH-1:0] alu_data2;
  logic [2:0]       alu_select;
  logic [WIDTH-1:0] product;
  logic             busy;
  logic             done;
  logic             stall;

  modport master (
    output start, opa, opb, cpu_data1, cpu_data2, cpu_select, alu_result,
    input  alu_data1, alu_data2, alu_select, product, busy, done, stall
  );

  modport slave (
    input  start, opa, opb, cpu_data1, cpu_data2, cpu_select, alu_result,
    output alu_data1, alu_data2, alu_select, product, busy, done, stall
  );

endinterface

// File: rtl/alu_port_mux.sv
// 2:1 selector for the ALU input ports.
//   sel_seq=0: CPU drives DATA1/DATA2/SELECT
//   sel_seq=1: the multiply sequencer drives them
module alu_port_mux import alu_defs_pkg::*; #(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             sel_seq,
  input  logic [WIDTH-1:0] cpu_data1,
  input  logic [WIDTH-1:0] cpu_data2,
  input  logic [2:0]       cpu_select,
  input  logic [WIDTH-1:0] seq_data1,
  input  logic [WIDTH-1:0] seq_data2,
  input  logic [2:0]       seq_select,
  output logic [WIDTH-1:0] alu_data1,
  output logic [WIDTH-1:0] alu_data2,
  output logic [2:0]       alu_select
);

  assign alu_data1  = sel_seq ? seq_data1  : cpu_data1;
  assign alu_data2  = sel_seq ? seq_data2  : cpu_data2;
  assign alu_select = sel_seq ? seq_select : cpu_select;

endmodule

// File: rtl/alu_mul_sequencer.sv
// Iterative shift-and-add multiplier that borrows the shared single-cycle ALU.
// In IDLE/DONE the CPU owns the ALU; in RUN the sequencer issues one ADD per
// cycle (acc + (mplier[0] ? mcand : 0)) and returns the low WIDTH bits of
// opa*opb on product, pulsing done for one cycle.
//   clk    rising-edge clock
//   reset  synchronous, active-high; discards any multiply in flight
//   bus    slave side of alu_mul_sequencer_if
module alu_mul_sequencer import alu_defs_pkg::*; #(
  parameter int         WIDTH      = ALU_WIDTH,
  parameter logic [2:0] ADD_SEL    = ALU_ADD,
  parameter bit         EARLY_EXIT = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  alu_mul_sequencer_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  seq_state_t       state;
  seq_state_t       state_next;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] product_q;
  logic             last_step;
  logic             in_run;

  assign in_run = (state == RUN);

  // The ADD issued this cycle is the last one either when every multiplier
  // bit has been consumed, or (early exit) when no set bits remain above
  // the one being processed now.
  assign last_step = (cnt == CNT_W'(WIDTH - 1)) ||
                     (EARLY_EXIT && ((mplier >> 1) == '0));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; START is only honoured in IDLE, never queued.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operands latch on an accepted start, then each RUN cycle folds
  // the ALU sum back into acc and shifts to the next multiplier bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      product_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand  <= bus.opa;
            mplier <= bus.opb;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          acc    <= bus.alu_result;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (last_step) begin
            product_q <= bus.alu_result;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Only RUN takes the ALU away from the CPU.
  alu_port_mux #(.WIDTH(WIDTH)) u_mux (
    .sel_seq    (in_run),
    .cpu_data1  (bus.cpu_data1),
    .cpu_data2  (bus.cpu_data2),
    .cpu_select (bus.cpu_select),
    .seq_data1  (acc),
    .seq_data2  (mplier[0] ? mcand : '0),
    .seq_select (ADD_SEL),
    .alu_data1  (bus.alu_data1),
    .alu_data2  (bus.alu_data2),
    .alu_select (bus.alu_select)
  );

  assign bus.busy    = in_run;
  assign bus.stall   = in_run;
  assign bus.done    = (state == DONE);
  assign bus.product = product_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer. Two instances share one stimulus
// stream: dut0 runs the full WIDTH steps, dut1 exits early. Each instance has
// its own copy of the ALU on its ALU_* ports.
module tb_alu_mul_sequencer;
  import alu_defs_pkg::*;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] opa;
  logic [7:0] opb;
  logic [7:0] cpu_data1;
  logic [7:0] cpu_data2;
  logic [2:0] cpu_select;

  int tests_run    = 0;
  int tests_failed = 0;
  bit check_en     = 1'b0;

  // Reference-model state, one slot per instance.
  int m_mode [2];
  int m_left [2];
  int m_step [2];
  int m_a    [2];
  int m_b    [2];
  int m_prod [2];

  always #5 clk = ~clk;

  alu_mul_sequencer_if #(.WIDTH(W)) bus0 ();
  alu_mul_sequencer_if #(.WIDTH(W)) bus1 ();

  // The single-cycle ALU being shared.
  function automatic logic [7:0] alu_fn(input logic [7:0] d1, input logic [7:0] d2,
                                        input logic [2:0] sel);
    case (sel)
      ALU_FWD: return d2;
      ALU_ADD: return d1 + d2;
      ALU_AND: return d1 & d2;
      ALU_OR:  return d1 | d2;
      default: return 8'h00;
    endcase
  endfunction

  assign bus0.start      = start;
  assign bus0.opa        = opa;
  assign bus0.opb        = opb;
  assign bus0.cpu_data1  = cpu_data1;
  assign bus0.cpu_data2  = cpu_data2;
  assign bus0.cpu_select = cpu_select;
  assign bus0.alu_result = alu_fn(bus0.alu_data1, bus0.alu_data2, bus0.alu_select);

  assign bus1.start      = start;
  assign bus1.opa        = opa;
  assign bus1.opb        = opb;
  assign bus1.cpu_data1  = cpu_data1;
  assign bus1.cpu_data2  = cpu_data2;
  assign bus1.cpu_select = cpu_select;
  assign bus1.alu_result = alu_fn(bus1.alu_data1, bus1.alu_data2, bus1.alu_select);

  alu_mul_sequencer #(.WIDTH(W), .ADD_SEL(ALU_ADD), .EARLY_EXIT(1'b0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  alu_mul_sequencer #(.WIDTH(W), .ADD_SEL(ALU_ADD), .EARLY_EXIT(1'b1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  // Number of RUN cycles: always W, or with early exit the bit length of the
  // multiplier (at least one ADD is always issued).
  function automatic int run_len(input bit early, input int b);
    int n;
    if (!early) return W;
    n = 0;
    for (int i = 0; i < W; i++) if (((b >> i) & 1) != 0) n = i + 1;
    return (n == 0) ? 1 : n;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic [7:0] a,
                               input logic [7:0] b, input logic [7:0] d1,
                               input logic [7:0] d2, input logic [2:0] sel);
    reset      = r;
    start      = s;
    opa        = a;
    opb        = b;
    cpu_data1  = d1;
    cpu_data2  = d2;
    cpu_select = sel;
    tick();
  endtask

  // Behavioural model: a multiply takes run_len cycles, then one DONE cycle,
  // and yields (a*b) mod 256. Reset wins over everything.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_mode[d] = 0;
        m_prod[d] = 0;
      end else begin
        case (m_mode[d])
          0: if (start) begin
            m_mode[d] = 1;
            m_a[d]    = int'(opa);
            m_b[d]    = int'(opb);
            m_step[d] = 0;
            m_left[d] = run_len(d == 1, int'(opb));
          end
          1: begin
            m_step[d]++;
            m_left[d]--;
            if (m_left[d] == 0) begin
              m_mode[d] = 2;
              m_prod[d] = (m_a[d] * m_b[d]) & 255;
            end
          end
          default: m_mode[d] = 0;
        endcase
      end
    end
  end

  // During step s of a multiply the ALU sees the partial product of the low
  // s multiplier bits, plus the multiplicand scaled by bit s when that bit is set.
  task automatic compare_dut(input int d, input logic [7:0] prod, input logic busy,
                             input logic done, input logic stall,
                             input logic [7:0] d1, input logic [7:0] d2,
                             input logic [2:0] sel);
    int e_d1, e_d2, e_sel, a, b, s;
    a = m_a[d];
    b = m_b[d];
    s = m_step[d];
    if (m_mode[d] == 1) begin
      e_d1  = (a * (b & ((1 << s) - 1))) & 255;
      e_d2  = (((b >> s) & 1) != 0) ? ((a << s) & 255) : 0;
      e_sel = int'(ALU_ADD);
    end else begin
      e_d1  = int'(cpu_data1);
      e_d2  = int'(cpu_data2);
      e_sel = int'(cpu_select);
    end
    checkOutput($sformatf("dut%0d.product", d), 32'(prod), 32'(m_prod[d]));
    checkOutput($sformatf("dut%0d.busy", d),    32'(busy), 32'(m_mode[d] == 1));
    checkOutput($sformatf("dut%0d.stall", d),   32'(stall), 32'(m_mode[d] == 1));
    checkOutput($sformatf("dut%0d.done", d),    32'(done), 32'(m_mode[d] == 2));
    checkOutput($sformatf("dut%0d.alu_data1", d),  32'(d1),  32'(e_d1));
    checkOutput($sformatf("dut%0d.alu_data2", d),  32'(d2),  32'(e_d2));
    checkOutput($sformatf("dut%0d.alu_select", d), 32'(sel), 32'(e_sel));
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      compare_dut(0, bus0.product, bus0.busy, bus0.done, bus0.stall,
                  bus0.alu_data1, bus0.alu_data2, bus0.alu_select);
      compare_dut(1, bus1.product, bus1.busy, bus1.done, bus1.stall,
                  bus1.alu_data1, bus1.alu_data2, bus1.alu_select);
    end
  end

  // One start pulse, then 12 observed cycles beginning right after the
  // accepting edge. second_at >= 0 raises start again so it is sampled at
  // edge k+second_at+1 with different operands, which must be ignored.
  task automatic run_mul(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_prod, input int exp_busy1,
                         input int second_at);
    int busy0, busy1, done0, done1, done_at0, done_at1;
    logic [7:0] prod0, prod1;
    busy0 = 0; busy1 = 0; done0 = 0; done1 = 0; done_at0 = -1; done_at1 = -1;
    prod0 = 'x; prod1 = 'x;
    start = 1'b1; opa = a; opb = b;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bus0.busy) busy0++;
      if (bus1.busy) busy1++;
      if (bus0.done) begin done0++; done_at0 = i; prod0 = bus0.product; end
      if (bus1.done) begin done1++; done_at1 = i; prod1 = bus1.product; end
      if (i == second_at) begin
        start = 1'b1; opa = 8'h09; opb = 8'h09;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    checkOutput("mul.busy_cycles0", 32'(busy0), 32'd8);
    checkOutput("mul.busy_cycles1", 32'(busy1), 32'(exp_busy1));
    checkOutput("mul.done_count0", 32'(done0), 32'd1);
    checkOutput("mul.done_count1", 32'(done1), 32'd1);
    checkOutput("mul.done_at0", 32'(done_at0), 32'd8);
    checkOutput("mul.done_at1", 32'(done_at1), 32'(exp_busy1));
    checkOutput("mul.product0", 32'(prod0), 32'(exp_prod));
    checkOutput("mul.product1", 32'(prod1), 32'(exp_prod));
  endtask

  // Directed scenarios with hand-computed expectations, then random traffic.
  initial begin
    int dn0, dn1;
    reset = 1'b1; start = 1'b0; opa = '0; opb = '0;
    cpu_data1 = '0; cpu_data2 = '0; cpu_select = '0;
    tick();
    tick();
    check_en = 1'b1;
    checkOutput("reset.known0", 32'($isunknown({bus0.product, bus0.busy, bus0.done,
                bus0.stall, bus0.alu_data1, bus0.alu_data2, bus0.alu_select})), 32'd0);
    checkOutput("reset.known1", 32'($isunknown({bus1.product, bus1.busy, bus1.done,
                bus1.stall, bus1.alu_data1, bus1.alu_data2, bus1.alu_select})), 32'd0);
    checkOutput("reset.product0", 32'(bus0.product), 32'h0);
    checkOutput("reset.busy0", 32'(bus0.busy), 32'h0);
    checkOutput("reset.done0", 32'(bus0.done), 32'h0);
    checkOutput("reset.stall0", 32'(bus0.stall), 32'h0);
    reset = 1'b0;

    // CPU pass-through while idle.
    cpu_data1 = 8'hF0; cpu_data2 = 8'h3C; cpu_select = ALU_AND;
    tick();
    checkOutput("idle.alu_data1", 32'(bus0.alu_data1), 32'hF0);
    checkOutput("idle.alu_data2", 32'(bus0.alu_data2), 32'h3C);
    checkOutput("idle.alu_select", 32'(bus0.alu_select), 32'h2);
    checkOutput("idle.alu_result", 32'(bus0.alu_result), 32'h30);
    checkOutput("idle.stall", 32'(bus0.stall), 32'h0);

    run_mul(8'd5,  8'd3,  8'h0F, 2, -1);
    run_mul(8'hFF, 8'hFF, 8'h01, 8, -1);
    run_mul(8'h00, 8'hA5, 8'h00, 8, -1);
    run_mul(8'd5,  8'd3,  8'h0F, 2, 2);
    run_mul(8'd7,  8'd2,  8'd14, 2, -1);

    // Reset in the middle of a multiply.
    start = 1'b1; opa = 8'd5; opb = 8'd3;
    tick();
    start = 1'b0;
    repeat (3) tick();
    reset = 1'b1; cpu_data1 = 8'h12; cpu_data2 = 8'h34; cpu_select = ALU_OR;
    tick();
    checkOutput("abort.busy", 32'(bus0.busy), 32'h0);
    checkOutput("abort.done", 32'(bus0.done), 32'h0);
    checkOutput("abort.product", 32'(bus0.product), 32'h0);
    checkOutput("abort.alu_data1", 32'(bus0.alu_data1), 32'h12);
    checkOutput("abort.alu_data2", 32'(bus0.alu_data2), 32'h34);
    checkOutput("abort.alu_select", 32'(bus0.alu_select), 32'h3);
    reset = 1'b0;
    tick();

    // start held high: one multiply per 10 cycles (dut0), per 3 (dut1, b=1).
    dn0 = 0; dn1 = 0;
    start = 1'b1; opa = 8'd6; opb = 8'd1;
    tick();
    for (int i = 0; i < 30; i++) begin
      if (bus0.done) dn0++;
      if (bus1.done) dn1++;
      if (i == 29) start = 1'b0;
      tick();
    end
    checkOutput("hold.done_count0", 32'(dn0), 32'd3);
    checkOutput("hold.done_count1", 32'(dn1), 32'd10);
    checkOutput("hold.product0", 32'(bus0.product), 32'd6);
    repeat (12) tick();

    // Random traffic; small multipliers are favoured to exercise early exit.
    for (int c = 0; c < 3000; c++) begin
      applyStimulus($urandom_range(0, 199) == 0,
                    $urandom_range(0, 2) == 0,
                    8'($urandom),
                    ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom_range(0, 7)),
                    8'($urandom), 8'($urandom), 3'($urandom_range(0, 3)));
    end
    start = 1'b0;
    reset = 1'b0;
    repeat (12) tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
